// File: rtl/ball_hit_tracker.sv
// Frame centroid tracker: accumulates qualified hit pixels, divides at frame end,
// and flags a collision when centroid motion opposes the ball's direction.
module ball_hit_tracker #(
  parameter int X_W            = 10,
  parameter int Y_W            = 10,
  parameter int CNT_W          = 12,
  parameter int MIN_PIXELS     = 20,
  parameter int MIN_SPEED      = 1,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic           clk_25MHz,
  input  logic           reset,
  input  logic [X_W-1:0] x_pixel,
  input  logic [Y_W-1:0] y_pixel,
  input  logic           pixel_valid,
  input  logic           is_hit_area,
  input  logic           is_target_color,
  input  logic           is_ball_moving_left,
  input  logic           frame_end,
  output logic           busy,
  output logic           hit_valid,
  output logic [X_W-1:0] hit_center_x,
  output logic [Y_W-1:0] hit_center_y,
  output logic           collision_detected,
  output logic [X_W-1:0] estimated_speed
);

  localparam int SX_W = X_W + CNT_W;
  localparam int SY_W = Y_W + CNT_W;
  localparam int DW   = (X_W > Y_W) ? X_W : Y_W;
  localparam int IT_W = $clog2(DW + 1);
  localparam int HO_W = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);
  localparam logic signed [X_W:0] MS  = (X_W+1)'(MIN_SPEED);
  localparam logic signed [X_W:0] NMS = -MS;

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, COMPARE} state_t;

  state_t            state_q, state_d;
  logic [SX_W-1:0]   sum_x_q, sum_x_d;
  logic [SY_W-1:0]   sum_y_q, sum_y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SY_W-1:0]   snap_y_q, snap_y_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DW-1:0]     low_q, low_d;
  logic [IT_W-1:0]   iter_q, iter_d;
  logic [X_W-1:0]    cx_q, cx_d;
  logic [Y_W-1:0]    cy_q, cy_d;
  logic [X_W-1:0]    prev_x_q, prev_x_d;
  logic              prev_valid_q, prev_valid_d;
  logic [HO_W-1:0]   holdoff_q, holdoff_d;
  logic              discard_q, discard_d;
  logic              hit_valid_q, hit_valid_d;
  logic              collision_q, collision_d;
  logic [X_W-1:0]    hit_cx_q, hit_cx_d;
  logic [Y_W-1:0]    hit_cy_q, hit_cy_d;
  logic [X_W-1:0]    speed_q, speed_d;

  logic              qual;
  logic [SX_W-1:0]   sx_n;
  logic [SY_W-1:0]   sy_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W:0]    trial;
  logic              ge;
  logic [CNT_W-1:0]  rem_n;
  logic [DW-1:0]     low_n;
  logic signed [X_W:0] dx;
  logic              coll;

  assign busy               = (state_q != IDLE);
  assign hit_valid          = hit_valid_q;
  assign collision_detected = collision_q;
  assign hit_center_x       = hit_cx_q;
  assign hit_center_y       = hit_cy_q;
  assign estimated_speed    = speed_q;

  // Running sums including the current pixel, so a pixel coincident with
  // frame_end lands in the ending frame's snapshot.
  always_comb begin
    qual  = pixel_valid & is_hit_area & is_target_color;
    sx_n  = sum_x_q;
    sy_n  = sum_y_q;
    cnt_n = cnt_q;
    if (qual && (cnt_q != '1)) begin
      sx_n  = sum_x_q + SX_W'(x_pixel);
      sy_n  = sum_y_q + SY_W'(y_pixel);
      cnt_n = cnt_q + CNT_W'(1);
    end
  end

  // One restoring-division step: remainder stays below the divisor.
  always_comb begin
    trial = {rem_q, low_q[DW-1]};
    ge    = (trial >= {1'b0, div_q});
    rem_n = ge ? CNT_W'(trial - {1'b0, div_q}) : trial[CNT_W-1:0];
    low_n = {low_q[DW-2:0], ge};
  end

  always_comb begin
    dx   = $signed({1'b0, cx_q}) - $signed({1'b0, prev_x_q});
    coll = prev_valid_q && (holdoff_q == '0) &&
           (( is_ball_moving_left && (dx >= MS)) ||
            (!is_ball_moving_left && (dx <= NMS)));
  end

  always_comb begin
    state_d      = state_q;
    sum_x_d      = sx_n;
    sum_y_d      = sy_n;
    cnt_d        = cnt_n;
    snap_y_d     = snap_y_q;
    div_d        = div_q;
    rem_d        = rem_q;
    low_d        = low_q;
    iter_d       = iter_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    prev_x_d     = prev_x_q;
    prev_valid_d = prev_valid_q;
    holdoff_d    = holdoff_q;
    discard_d    = discard_q;
    hit_valid_d  = 1'b0;
    collision_d  = 1'b0;
    hit_cx_d     = hit_cx_q;
    hit_cy_d     = hit_cy_q;
    speed_d      = speed_q;

    if (frame_end) begin
      sum_x_d = '0;
      sum_y_d = '0;
      cnt_d   = '0;
      if (holdoff_q != '0) holdoff_d = holdoff_q - HO_W'(1);
      if (busy) begin
        discard_d = 1'b1;
      end else if (cnt_n >= CNT_W'(MIN_PIXELS)) begin
        state_d  = DIV_X;
        div_d    = cnt_n;
        rem_d    = sx_n[SX_W-1:X_W];
        low_d    = DW'(sx_n[X_W-1:0]) << (DW - X_W);
        iter_d   = '0;
        snap_y_d = sy_n;
      end else begin
        prev_valid_d = 1'b0;
      end
    end

    unique case (state_q)
      DIV_X: begin
        rem_d  = rem_n;
        low_d  = low_n;
        iter_d = iter_q + IT_W'(1);
        if (iter_q == IT_W'(X_W - 1)) begin
          cx_d    = low_n[X_W-1:0];
          rem_d   = snap_y_q[SY_W-1:Y_W];
          low_d   = DW'(snap_y_q[Y_W-1:0]) << (DW - Y_W);
          iter_d  = '0;
          state_d = DIV_Y;
        end
      end
      DIV_Y: begin
        rem_d  = rem_n;
        low_d  = low_n;
        iter_d = iter_q + IT_W'(1);
        if (iter_q == IT_W'(Y_W - 1)) begin
          cy_d    = low_n[Y_W-1:0];
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        hit_valid_d = 1'b1;
        hit_cx_d    = cx_q;
        hit_cy_d    = cy_q;
        if (coll) begin
          collision_d = 1'b1;
          speed_d     = X_W'(dx[X_W] ? -dx : dx);
          holdoff_d   = HO_W'(HOLDOFF_FRAMES);
        end
        prev_x_d     = cx_q;
        // A frame dropped while busy breaks frame-to-frame continuity.
        prev_valid_d = !(discard_q || frame_end);
        discard_d    = 1'b0;
        state_d      = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      cnt_q        <= '0;
      snap_y_q     <= '0;
      div_q        <= '0;
      rem_q        <= '0;
      low_q        <= '0;
      iter_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      prev_x_q     <= '0;
      prev_valid_q <= 1'b0;
      holdoff_q    <= '0;
      discard_q    <= 1'b0;
      hit_valid_q  <= 1'b0;
      collision_q  <= 1'b0;
      hit_cx_q     <= '0;
      hit_cy_q     <= '0;
      speed_q      <= '0;
    end else begin
      state_q      <= state_d;
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      cnt_q        <= cnt_d;
      snap_y_q     <= snap_y_d;
      div_q        <= div_d;
      rem_q        <= rem_d;
      low_q        <= low_d;
      iter_q       <= iter_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      prev_x_q     <= prev_x_d;
      prev_valid_q <= prev_valid_d;
      holdoff_q    <= holdoff_d;
      discard_q    <= discard_d;
      hit_valid_q  <= hit_valid_d;
      collision_q  <= collision_d;
      hit_cx_q     <= hit_cx_d;
      hit_cy_q     <= hit_cy_d;
      speed_q      <= speed_d;
    end
  end

endmodule

// File: tb/tb_ball_hit_tracker.sv
// Directed bench for ball_hit_tracker: centroid, latency, direction,
// invalid frames, holdoff, busy discard and mid-divide reset.
module tb_ball_hit_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_pixel, y_pixel;
  logic       pixel_valid, is_hit_area, is_target_color;
  logic       is_ball_moving_left, frame_end;
  logic       busy, hit_valid, collision_detected;
  logic [9:0] hit_center_x, hit_center_y, estimated_speed;

  int checks = 0;
  int failures = 0;

  int hv_cnt, hv_first, col_cnt, col_first, busy_seen;
  logic [9:0] cap_x, cap_y, end_x, end_y;

  ball_hit_tracker dut (
    .clk_25MHz(clk),
    .reset(reset),
    .x_pixel(x_pixel),
    .y_pixel(y_pixel),
    .pixel_valid(pixel_valid),
    .is_hit_area(is_hit_area),
    .is_target_color(is_target_color),
    .is_ball_moving_left(is_ball_moving_left),
    .frame_end(frame_end),
    .busy(busy),
    .hit_valid(hit_valid),
    .hit_center_x(hit_center_x),
    .hit_center_y(hit_center_y),
    .collision_detected(collision_detected),
    .estimated_speed(estimated_speed)
  );

  always #20 clk = ~clk;

  task automatic idle_inputs();
    pixel_valid     = 1'b0;
    is_hit_area     = 1'b0;
    is_target_color = 1'b0;
    frame_end       = 1'b0;
    x_pixel         = '0;
    y_pixel         = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // n qualified pixels x0..x0+n-1 at row y0, each followed by a
  // non-qualified decoy pixel at (1023,1023)
  task automatic send_pixels(input int n, input int x0, input int y0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1; is_hit_area = 1'b1; is_target_color = 1'b1;
      x_pixel = 10'(x0 + i); y_pixel = 10'(y0);
      @(negedge clk);
      x_pixel = 10'd1023; y_pixel = 10'd1023;
      pixel_valid     = (i % 3) != 0;
      is_hit_area     = (i % 3) != 1;
      is_target_color = (i % 3) != 2;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Pulse frame_end, then watch ncyc cycles. Sample k lies between the
  // (k-1)th and kth rising edge after the one that took frame_end.
  // With inject, 20 more pixels arrive during the divide and a second
  // frame_end lands on the cycle the first frame is in COMPARE.
  task automatic frame_and_watch(input int ncyc, input bit inject);
    @(negedge clk);
    frame_end = 1'b1;
    @(posedge clk);
    hv_cnt = 0; hv_first = 0; col_cnt = 0; col_first = 0;
    cap_x = '0; cap_y = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        frame_end = 1'b0;
        busy_seen = int'(busy);
      end
      if (inject) begin
        if (k >= 2 && k <= 21) begin
          pixel_valid = 1'b1; is_hit_area = 1'b1; is_target_color = 1'b1;
          x_pixel = 10'(200 + k); y_pixel = 10'd60;
        end
        frame_end = (k == 21);
        if (k == 22) idle_inputs();
      end
      if (hit_valid) begin
        hv_cnt++;
        if (hv_first == 0) begin
          hv_first = k;
          cap_x = hit_center_x;
          cap_y = hit_center_y;
        end
      end
      if (collision_detected) begin
        col_cnt++;
        if (col_first == 0) col_first = k;
      end
    end
    end_x = hit_center_x;
    end_y = hit_center_y;
  endtask

  task automatic run_frame(input int n, input int cx, input int y0, input bit left);
    is_ball_moving_left = left;
    send_pixels(n, cx - (n - 1) / 2, y0);
    frame_and_watch(30, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    is_ball_moving_left = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, hit_valid, collision_detected} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000", {busy, hit_valid, collision_detected});
    end
    checks++;
    if ({hit_center_x, hit_center_y, estimated_speed} !== 30'd0) begin
      failures++;
      $display("FAIL reset_values got x=%0d y=%0d spd=%0d want 0 0 0",
               hit_center_x, hit_center_y, estimated_speed);
    end
    reset = 1'b0;
    frame_and_watch(30, 1'b0);
    checks++;
    if (hv_cnt != 0 || col_cnt != 0) begin
      failures++;
      $display("FAIL empty_frame_pulses got hv=%0d col=%0d want 0 0", hv_cnt, col_cnt);
    end
    checks++;
    if (busy_seen != 0) begin
      failures++;
      $display("FAIL empty_frame_busy got=%0d want=0", busy_seen);
    end
  endtask

  task automatic test_centroid();
    do_reset();
    run_frame(20, 109, 50, 1'b1);
    checks++;
    if (busy_seen != 1) begin
      failures++;
      $display("FAIL centroid_busy got=%0d want=1", busy_seen);
    end
    checks++;
    if (hv_first != 22 || hv_cnt != 1) begin
      failures++;
      $display("FAIL centroid_latency got at=%0d n=%0d want at=22 n=1", hv_first, hv_cnt);
    end
    checks++;
    if (cap_x !== 10'd109 || cap_y !== 10'd50) begin
      failures++;
      $display("FAIL centroid_value got=(%0d,%0d) want=(109,50)", cap_x, cap_y);
    end
    checks++;
    if (col_cnt != 0) begin
      failures++;
      $display("FAIL centroid_no_prev_col got=%0d want=0", col_cnt);
    end
    checks++;
    if (end_x !== 10'd109 || end_y !== 10'd50) begin
      failures++;
      $display("FAIL centroid_hold got=(%0d,%0d) want=(109,50)", end_x, end_y);
    end
  endtask

  task automatic test_direction();
    do_reset();
    run_frame(20, 109, 40, 1'b1);
    run_frame(20, 115, 40, 1'b1);
    checks++;
    if (col_cnt != 1 || col_first != 22) begin
      failures++;
      $display("FAIL dir_left_col got n=%0d at=%0d want n=1 at=22", col_cnt, col_first);
    end
    checks++;
    if (estimated_speed !== 10'd6) begin
      failures++;
      $display("FAIL dir_left_speed got=%0d want=6", estimated_speed);
    end
    // dx=-6 with left=0 would collide, but holdoff is 1 here
    run_frame(20, 109, 40, 1'b0);
    checks++;
    if (col_cnt != 0 || hv_cnt != 1) begin
      failures++;
      $display("FAIL dir_holdoff got col=%0d hv=%0d want col=0 hv=1", col_cnt, hv_cnt);
    end
    run_frame(20, 115, 40, 1'b0);
    checks++;
    if (col_cnt != 0) begin
      failures++;
      $display("FAIL dir_right_nocol got=%0d want=0", col_cnt);
    end
    checks++;
    if (estimated_speed !== 10'd6) begin
      failures++;
      $display("FAIL dir_speed_held got=%0d want=6", estimated_speed);
    end
  endtask

  task automatic test_small_frame();
    do_reset();
    run_frame(20, 109, 30, 1'b1);
    run_frame(19, 119, 30, 1'b1);
    checks++;
    if (hv_cnt != 0 || busy_seen != 0) begin
      failures++;
      $display("FAIL small_frame got hv=%0d busy=%0d want 0 0", hv_cnt, busy_seen);
    end
    checks++;
    if (end_x !== 10'd109) begin
      failures++;
      $display("FAIL small_frame_hold got=%0d want=109", end_x);
    end
    run_frame(20, 115, 30, 1'b1);
    checks++;
    if (hv_cnt != 1 || cap_x !== 10'd115 || col_cnt != 0) begin
      failures++;
      $display("FAIL small_frame_prev got hv=%0d x=%0d col=%0d want 1 115 0",
               hv_cnt, cap_x, col_cnt);
    end
  endtask

  task automatic test_holdoff();
    do_reset();
    run_frame(20, 100, 20, 1'b1);
    run_frame(20, 106, 20, 1'b1);
    checks++;
    if (col_cnt != 1) begin
      failures++;
      $display("FAIL holdoff_first got=%0d want=1", col_cnt);
    end
    run_frame(20, 112, 20, 1'b1);
    checks++;
    if (col_cnt != 0 || hv_cnt != 1) begin
      failures++;
      $display("FAIL holdoff_suppress got col=%0d hv=%0d want 0 1", col_cnt, hv_cnt);
    end
    checks++;
    if (estimated_speed !== 10'd6) begin
      failures++;
      $display("FAIL holdoff_speed_held got=%0d want=6", estimated_speed);
    end
    run_frame(20, 120, 20, 1'b1);
    checks++;
    if (col_cnt != 1 || estimated_speed !== 10'd8) begin
      failures++;
      $display("FAIL holdoff_release got col=%0d spd=%0d want 1 8", col_cnt, estimated_speed);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_frame(20, 109, 70, 1'b0);
    is_ball_moving_left = 1'b0;
    send_pixels(20, 106, 70);
    frame_and_watch(60, 1'b1);
    checks++;
    if (hv_cnt != 1 || hv_first != 22 || cap_x !== 10'd115) begin
      failures++;
      $display("FAIL busy_discard got n=%0d at=%0d x=%0d want 1 22 115",
               hv_cnt, hv_first, cap_x);
    end
    checks++;
    if (col_cnt != 0) begin
      failures++;
      $display("FAIL busy_discard_col got=%0d want=0", col_cnt);
    end
    run_frame(20, 121, 70, 1'b1);
    checks++;
    if (hv_cnt != 1 || col_cnt != 0) begin
      failures++;
      $display("FAIL busy_prev_cleared got hv=%0d col=%0d want 1 0", hv_cnt, col_cnt);
    end
  endtask

  task automatic test_reset_mid_divide();
    int pulses;
    do_reset();
    is_ball_moving_left = 1'b1;
    send_pixels(20, 100, 10);
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_div_busy got=%b want=1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_div_reset_busy got=%b want=0", busy);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hit_valid || collision_detected || busy) pulses++;
    end
    checks++;
    if (pulses != 0 || hit_center_x !== 10'd0) begin
      failures++;
      $display("FAIL mid_div_no_pulse got n=%0d x=%0d want 0 0", pulses, hit_center_x);
    end
  endtask

  initial begin
    reset = 1'b1;
    is_ball_moving_left = 1'b0;
    idle_inputs();
    test_reset();
    test_centroid();
    test_direction();
    test_small_frame();
    test_holdoff();
    test_back_to_back();
    test_reset_mid_divide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
